// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data memory between the CPU control path and the
// debug/program-loader port. Each grant runs a fixed three-state sequence:
// IDLE (arbitrate and latch), ACC (memory strobe), DONE (ack to the winner).
//
// state | meaning
// IDLE  | waiting; picks a winner among eligible requests and latches its access
// ACC   | mem_en high for one cycle with the latched address/data/we
// DONE  | winner's ack pulses; read data forwarded from mem_rdata
//
// Ports
//   clock, reset             rising-edge clock, synchronous active-low reset
//   cpu_req/we/addr/wdata    CPU request (sampled only at grant)
//   cpu_ack/rdata/stall      CPU completion pulse, read data, stall
//   dbg_req/we/addr/wdata    debug request (sampled only at grant)
//   dbg_ack/rdata            debug completion pulse, read data
//   dbg_lock                 1 = CPU never granted
//   mem_en/we/addr/wdata     memory access strobe and latched access
//   mem_rdata                registered memory read data (1 cycle after mem_en)
//   owner                    0 = CPU, 1 = DBG; owner of current/last grant
//   busy                     1 whenever not IDLE
module dmem_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int PRIORITY = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              dbg_lock,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              we_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic              cpu_elig;
    logic              dbg_elig;
    logic              grant;
    logic              grant_dbg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_dbg = 1'b0;
        cpu_elig  = cpu_req & ~dbg_lock;
        dbg_elig  = dbg_req;
        busy      = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        cpu_ack   = 1'b0;
        dbg_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_elig | dbg_elig) begin
                    grant     = 1'b1;
                    state_nxt = ACC;
                    // Round-robin: on a tie the port that was not last owner wins.
                    if (PRIORITY == 0) begin
                        grant_dbg = dbg_elig & (~cpu_elig | ~owner);
                    end else begin
                        grant_dbg = dbg_elig & ~cpu_elig;
                    end
                end
            end
            ACC: begin
                busy      = 1'b1;
                mem_en    = 1'b1;
                mem_we    = we_q;
                state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                cpu_ack   = ~owner;
                dbg_ack   = owner;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Read data is forwarded straight from the memory during the ack
        // cycle so it is valid while ack is high; the register holds it after.
        cpu_rdata = (cpu_ack & ~we_q) ? mem_rdata : cpu_rdata_q;
        dbg_rdata = (dbg_ack & ~we_q) ? mem_rdata : dbg_rdata_q;
        cpu_stall = cpu_req & ~cpu_ack;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            owner       <= 1'b1;
            we_q        <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            if (grant) begin
                owner     <= grant_dbg;
                we_q      <= grant_dbg ? dbg_we    : cpu_we;
                mem_addr  <= grant_dbg ? dbg_addr  : cpu_addr;
                mem_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
            end
            if (cpu_ack & ~we_q) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (dbg_ack & ~we_q) begin
                dbg_rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (round-robin and CPU-priority) share
// the same requester inputs; each has its own memory and its own
// transaction-level reference model.
module tb_dmem_arbiter;

    logic       clock;
    logic       reset;
    logic       cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [3:0] cpu_addr, dbg_addr;
    logic [7:0] cpu_wdata, dbg_wdata;

    logic       cpu_ack_w [2];
    logic       cpu_stall_w [2];
    logic       dbg_ack_w [2];
    logic       mem_en_w [2];
    logic       mem_we_w [2];
    logic       owner_w [2];
    logic       busy_w [2];
    logic [7:0] cpu_rdata_w [2];
    logic [7:0] dbg_rdata_w [2];
    logic [7:0] mem_wdata_w [2];
    logic [7:0] mem_rdata_r [2];
    logic [3:0] mem_addr_w [2];

    // bench memories behind each DUT
    logic [7:0] mem [2][16];
    // reference model: a scheduled transaction per DUT
    int         cl [2];          // cycles left in the current transaction
    logic       own [2];
    logic       lwe [2];
    logic [3:0] laddr [2];
    logic [7:0] lwd [2];
    logic [7:0] trd [2];
    logic [7:0] hcpu [2];
    logic [7:0] hdbg [2];
    logic [7:0] rmem [2][16];
    // snapshots taken at the negedge of the last cycle
    logic       s_cpu_ack [2], s_dbg_ack [2], s_stall [2], s_en [2], s_we [2];
    logic       s_owner [2], s_busy [2];
    logic [7:0] s_cpu_rd [2], s_wd [2];
    logic [3:0] s_addr [2];

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.ADDR_W(4), .DATA_W(8), .PRIORITY(0)) dut0 (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack_w[0]), .cpu_rdata(cpu_rdata_w[0]), .cpu_stall(cpu_stall_w[0]),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack_w[0]), .dbg_rdata(dbg_rdata_w[0]), .dbg_lock(dbg_lock),
        .mem_en(mem_en_w[0]), .mem_we(mem_we_w[0]), .mem_addr(mem_addr_w[0]),
        .mem_wdata(mem_wdata_w[0]), .mem_rdata(mem_rdata_r[0]),
        .owner(owner_w[0]), .busy(busy_w[0])
    );

    dmem_arbiter #(.ADDR_W(4), .DATA_W(8), .PRIORITY(1)) dut1 (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack_w[1]), .cpu_rdata(cpu_rdata_w[1]), .cpu_stall(cpu_stall_w[1]),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack_w[1]), .dbg_rdata(dbg_rdata_w[1]), .dbg_lock(dbg_lock),
        .mem_en(mem_en_w[1]), .mem_we(mem_we_w[1]), .mem_addr(mem_addr_w[1]),
        .mem_wdata(mem_wdata_w[1]), .mem_rdata(mem_rdata_r[1]),
        .owner(owner_w[1]), .busy(busy_w[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int p, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, p, obs, exp);
        end
    endtask

    task automatic model_reset(input int p);
        cl[p]    = 0;
        own[p]   = 1'b1;
        lwe[p]   = 1'b0;
        laddr[p] = 4'd0;
        lwd[p]   = 8'd0;
        trd[p]   = 8'd0;
        hcpu[p]  = 8'd0;
        hdbg[p]  = 8'd0;
    endtask

    task automatic model_step(input int p);
        logic ce, de, wd;
        if (!reset) begin
            model_reset(p);
        end else if (cl[p] == 0) begin
            ce = cpu_req && !dbg_lock;
            de = dbg_req;
            if (ce || de) begin
                if (p == 0) wd = de && (!ce || !own[p]);
                else        wd = de && !ce;
                own[p]   = wd;
                lwe[p]   = wd ? dbg_we    : cpu_we;
                laddr[p] = wd ? dbg_addr  : cpu_addr;
                lwd[p]   = wd ? dbg_wdata : cpu_wdata;
                trd[p]   = rmem[p][laddr[p]];
                if (lwe[p]) rmem[p][laddr[p]] = lwd[p];
                cl[p] = 2;
            end
        end else begin
            if (cl[p] == 1 && !lwe[p]) begin
                if (own[p]) hdbg[p] = trd[p];
                else        hcpu[p] = trd[p];
            end
            cl[p] = cl[p] - 1;
        end
    endtask

    // one clock cycle: check at negedge, then advance memory and model after posedge
    task automatic cyc();
        logic ecack, edack;
        @(negedge clock);
        for (int p = 0; p < 2; p++) begin
            ecack = (cl[p] == 1) && !own[p];
            edack = (cl[p] == 1) && own[p];
            chk("busy",      p, busy_w[p],      cl[p] != 0);
            chk("mem_en",    p, mem_en_w[p],    cl[p] == 2);
            chk("mem_we",    p, mem_we_w[p],    (cl[p] == 2) && lwe[p]);
            chk("mem_addr",  p, mem_addr_w[p],  laddr[p]);
            chk("mem_wdata", p, mem_wdata_w[p], lwd[p]);
            chk("cpu_ack",   p, cpu_ack_w[p],   ecack);
            chk("dbg_ack",   p, dbg_ack_w[p],   edack);
            chk("cpu_rdata", p, cpu_rdata_w[p], (ecack && !lwe[p]) ? trd[p] : hcpu[p]);
            chk("dbg_rdata", p, dbg_rdata_w[p], (edack && !lwe[p]) ? trd[p] : hdbg[p]);
            chk("owner",     p, owner_w[p],     own[p]);
            chk("cpu_stall", p, cpu_stall_w[p], cpu_req && !ecack);
            s_cpu_ack[p] = cpu_ack_w[p];
            s_dbg_ack[p] = dbg_ack_w[p];
            s_stall[p]   = cpu_stall_w[p];
            s_en[p]      = mem_en_w[p];
            s_we[p]      = mem_we_w[p];
            s_owner[p]   = owner_w[p];
            s_busy[p]    = busy_w[p];
            s_cpu_rd[p]  = cpu_rdata_w[p];
            s_addr[p]    = mem_addr_w[p];
            s_wd[p]      = mem_wdata_w[p];
        end
        @(posedge clock);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (s_en[p]) begin
                mem_rdata_r[p] = mem[p][s_addr[p]];
                if (s_we[p]) mem[p][s_addr[p]] = s_wd[p];
            end
            model_step(p);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [7:0] v);
        for (int p = 0; p < 2; p++) begin
            mem[p][a]  = v;
            rmem[p][a] = v;
        end
    endtask

    initial begin
        int   cnt_cack1, cnt_dack1, cnt_dack0;
        logic found;
        logic [7:0] prev;

        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 4'd0; cpu_wdata = 8'd0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 4'd0; dbg_wdata = 8'd0;
        dbg_lock = 1'b0;
        for (int p = 0; p < 2; p++) begin
            mem_rdata_r[p] = 8'd0;
            model_reset(p);
            for (int a = 0; a < 16; a++) begin
                mem[p][a]  = 8'(a * 17 + 3);
                rmem[p][a] = 8'(a * 17 + 3);
            end
        end

        // both requests held from reset: RR alternates, CPU-priority starves DBG
        cpu_req = 1'b1;
        dbg_req = 1'b1;
        repeat (3) cyc();
        reset = 1'b1;
        cnt_cack1 = 0;
        cnt_dack1 = 0;
        for (int k = 0; k < 60; k++) begin
            cyc();
            if (k < 12) begin
                chk("rr_cpu_ack_time", 0, s_cpu_ack[0], (k == 2) || (k == 8));
                chk("rr_dbg_ack_time", 0, s_dbg_ack[0], (k == 5) || (k == 11));
            end
            if (s_cpu_ack[1]) cnt_cack1++;
            if (s_dbg_ack[1]) cnt_dack1++;
        end
        chk("prio_cpu_grants", 1, cnt_cack1, 20);
        chk("prio_no_dbg_ack", 1, cnt_dack1, 0);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        cyc();

        // CPU read of preloaded address 3
        preload(4'd3, 8'h5A);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd3;
        cyc();
        chk("rd_n_stall", 0, s_stall[0], 1);
        chk("rd_n_en", 0, s_en[0], 0);
        cyc();
        chk("rd_n1_en", 0, s_en[0], 1);
        chk("rd_n1_stall", 0, s_stall[0], 1);
        cyc();
        chk("rd_n2_ack", 0, s_cpu_ack[0], 1);
        chk("rd_n2_data", 0, s_cpu_rd[0], 8'h5A);
        chk("rd_n2_stall", 0, s_stall[0], 0);
        cpu_req = 1'b0;
        cyc();

        // CPU write of addr 2: rdata holds, mem_we only in the strobe cycle
        prev = s_cpu_rd[0];
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd2; cpu_wdata = 8'h11;
        cyc();
        chk("wr_n_we", 0, s_we[0], 0);
        cyc();
        chk("wr_n1_en", 0, s_en[0], 1);
        chk("wr_n1_we", 0, s_we[0], 1);
        cyc();
        chk("wr_n2_ack", 0, s_cpu_ack[0], 1);
        chk("wr_n2_rdata_held", 0, s_cpu_rd[0], prev);
        chk("wr_n2_we", 0, s_we[0], 0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        cyc();
        chk("wr_mem_content", 0, mem[0][2], 8'h11);

        // dbg_lock: only the loader is granted, then CPU reads its write
        dbg_lock = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd7;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 4'd7; dbg_wdata = 8'hC3;
        cnt_dack0 = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("lock_stall", 0, s_stall[0], 1);
            chk("lock_no_cpu_ack", 0, s_cpu_ack[0], 0);
            if (s_dbg_ack[0]) begin
                cnt_dack0++;
                dbg_req = 1'b0;
                dbg_we  = 1'b0;
            end
        end
        chk("lock_dbg_grants", 0, cnt_dack0, 1);
        dbg_lock = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (s_cpu_ack[0] && !found) begin
                found = 1'b1;
                chk("unlock_rdata", 0, s_cpu_rd[0], 8'hC3);
                cpu_req = 1'b0;
            end
        end
        chk("unlock_ack_seen", 0, found, 1);
        cpu_req = 1'b0;
        cyc();

        // reset during ACC aborts the access
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd5;
        cyc();
        reset = 1'b0;
        cyc();
        chk("abort_acc_en", 0, s_en[0], 1);
        reset = 1'b1;
        cpu_req = 1'b0;
        cyc();
        chk("abort_no_ack", 0, s_cpu_ack[0], 0);
        chk("abort_en", 0, s_en[0], 0);
        chk("abort_busy", 0, s_busy[0], 0);
        chk("abort_owner", 0, s_owner[0], 1);
        cyc();
        chk("abort_no_ack_later", 0, s_cpu_ack[0], 0);

        // randomized traffic, both DUTs against their models
        for (int k = 0; k < 600; k++) begin
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_we    = $urandom_range(0, 1) == 1;
            cpu_addr  = 4'($urandom_range(0, 15));
            cpu_wdata = 8'($urandom_range(0, 255));
            dbg_req   = ($urandom_range(0, 2) != 0);
            dbg_we    = $urandom_range(0, 1) == 1;
            dbg_addr  = 4'($urandom_range(0, 15));
            dbg_wdata = 8'($urandom_range(0, 255));
            dbg_lock  = ($urandom_range(0, 7) == 0);
            reset     = ($urandom_range(0, 79) != 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
